// File: rtl/instruction_decode.sv
// Decode stage: register file, jump/branch resolution with one-slot squash,
// and the registered ID/EX latch toward execute.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   instruc_reg         instruction word from fetch (one cycle behind PC)
//   PC_plus_1           combinational PC+1 from fetch
//   wb_we/addr/data     register-file write port from writeback
//   PC_sel, jump_addr   combinational redirect back to fetch
//   ex_*                registered ID/EX bundle toward execute
module instruction_decode #(
  parameter int PC_W  = 10,
  parameter int REG_N = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [31:0]     instruc_reg,
  input  logic [PC_W-1:0] PC_plus_1,
  input  logic            wb_we,
  input  logic [4:0]      wb_addr,
  input  logic [31:0]     wb_data,
  output logic            PC_sel,
  output logic [PC_W-1:0] jump_address,
  output logic            ex_valid,
  output logic [5:0]      ex_opcode,
  output logic [5:0]      ex_funct,
  output logic [4:0]      ex_shamt,
  output logic [4:0]      ex_rs,
  output logic [4:0]      ex_rt,
  output logic [4:0]      ex_rd,
  output logic [31:0]     ex_rs_data,
  output logic [31:0]     ex_rt_data,
  output logic [31:0]     ex_imm,
  output logic [PC_W-1:0] ex_link
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] FN_JR    = 6'h08;

  typedef struct packed {
    logic            valid;
    logic [5:0]      opcode;
    logic [5:0]      funct;
    logic [4:0]      shamt;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      rd;
    logic [31:0]     rs_data;
    logic [31:0]     rt_data;
    logic [31:0]     imm;
    logic [PC_W-1:0] link;
  } id_ex_t;

  logic [PC_W-1:0] pc_id_q, pc_id_d;
  logic            squash_q, squash_d;
  logic [31:0]     rf_q [REG_N];
  logic [31:0]     rf_d [REG_N];
  id_ex_t          ex_q, ex_d;

  logic [5:0]      opcode, funct;
  logic [4:0]      rs, rt;
  logic [31:0]     rs_data, rt_data;
  logic            id_valid;
  logic            is_j, is_jal, is_jr, is_beq, is_bne, is_alu_r;
  logic            taken;
  logic [PC_W-1:0] target;
  logic [4:0]      rd_sel;

  assign opcode   = instruc_reg[31:26];
  assign funct    = instruc_reg[5:0];
  assign rs       = instruc_reg[25:21];
  assign rt       = instruc_reg[20:16];
  assign id_valid = ~squash_q;

  assign is_j     = (opcode == OP_J);
  assign is_jal   = (opcode == OP_JAL);
  assign is_jr    = (opcode == OP_RTYPE) && (funct == FN_JR);
  assign is_beq   = (opcode == OP_BEQ);
  assign is_bne   = (opcode == OP_BNE);
  assign is_alu_r = (opcode == OP_RTYPE) && (funct != FN_JR);

  // Reads see the value being written this cycle (write-through).
  always_comb begin
    rs_data = '0;
    if (rs != 5'd0) begin
      if (wb_we && (wb_addr == rs)) rs_data = wb_data;
      else                          rs_data = rf_q[rs];
    end
  end

  always_comb begin
    rt_data = '0;
    if (rt != 5'd0) begin
      if (wb_we && (wb_addr == rt)) rt_data = wb_data;
      else                          rt_data = rf_q[rt];
    end
  end

  always_comb begin
    taken  = 1'b0;
    target = '0;
    unique case (1'b1)
      is_j, is_jal: begin
        taken  = 1'b1;
        target = instruc_reg[PC_W-1:0];
      end
      is_jr: begin
        taken  = 1'b1;
        target = rs_data[PC_W-1:0];
      end
      is_beq: begin
        taken  = (rs_data == rt_data);
        target = pc_id_q + instruc_reg[PC_W-1:0];
      end
      is_bne: begin
        taken  = (rs_data != rt_data);
        target = pc_id_q + instruc_reg[PC_W-1:0];
      end
      default: ;
    endcase
  end

  // A squashed slot or a cycle under reset never redirects fetch.
  assign PC_sel       = id_valid & ~reset & taken;
  assign jump_address = PC_sel ? target : '0;

  always_comb begin
    rd_sel = instruc_reg[20:16];
    unique case (1'b1)
      is_jal:                         rd_sel = 5'd31;
      is_j, is_jr, is_beq, is_bne:    rd_sel = 5'd0;
      is_alu_r:                       rd_sel = instruc_reg[15:11];
      default: ;
    endcase
  end

  always_comb begin
    ex_d = '0;
    if (id_valid) begin
      ex_d.valid   = 1'b1;
      ex_d.opcode  = opcode;
      ex_d.funct   = funct;
      ex_d.shamt   = instruc_reg[10:6];
      ex_d.rs      = rs;
      ex_d.rt      = rt;
      ex_d.rd      = rd_sel;
      ex_d.rs_data = rs_data;
      ex_d.rt_data = rt_data;
      ex_d.imm     = {{16{instruc_reg[15]}}, instruc_reg[15:0]};
      ex_d.link    = is_jal ? pc_id_q : '0;
    end
  end

  always_comb begin
    rf_d = rf_q;
    if (wb_we && (wb_addr != 5'd0)) rf_d[wb_addr] = wb_data;
  end

  assign squash_d = PC_sel;
  assign pc_id_d  = PC_plus_1;

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_id_q  <= '0;
      squash_q <= 1'b1;
      ex_q     <= '0;
      for (int i = 0; i < REG_N; i++) rf_q[i] <= '0;
    end else begin
      pc_id_q  <= pc_id_d;
      squash_q <= squash_d;
      ex_q     <= ex_d;
      rf_q     <= rf_d;
    end
  end

  assign ex_valid   = ex_q.valid;
  assign ex_opcode  = ex_q.opcode;
  assign ex_funct   = ex_q.funct;
  assign ex_shamt   = ex_q.shamt;
  assign ex_rs      = ex_q.rs;
  assign ex_rt      = ex_q.rt;
  assign ex_rd      = ex_q.rd;
  assign ex_rs_data = ex_q.rs_data;
  assign ex_rt_data = ex_q.rt_data;
  assign ex_imm     = ex_q.imm;
  assign ex_link    = ex_q.link;

endmodule

// File: tb/tb_instruction_decode.sv
// Bench for instruction_decode: directed vectors, a behavioural model
// checked every cycle, and literal expectations on key slots.
module tb_instruction_decode;

  localparam int PC_W = 10;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [31:0]     instruc_reg = '0;
  logic [PC_W-1:0] PC_plus_1 = '0;
  logic            wb_we = 1'b0;
  logic [4:0]      wb_addr = '0;
  logic [31:0]     wb_data = '0;

  logic            PC_sel;
  logic [PC_W-1:0] jump_address;
  logic            ex_valid;
  logic [5:0]      ex_opcode, ex_funct;
  logic [4:0]      ex_shamt, ex_rs, ex_rt, ex_rd;
  logic [31:0]     ex_rs_data, ex_rt_data, ex_imm;
  logic [PC_W-1:0] ex_link;

  instruction_decode #(.PC_W(PC_W), .REG_N(32)) dut (
    .clock(clock), .reset(reset),
    .instruc_reg(instruc_reg), .PC_plus_1(PC_plus_1),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .PC_sel(PC_sel), .jump_address(jump_address),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_funct(ex_funct),
    .ex_shamt(ex_shamt), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
    .ex_imm(ex_imm), .ex_link(ex_link)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Model state
  logic [31:0]     m_rf [32];
  logic            m_sq;
  logic [PC_W-1:0] m_pc;
  bit              m_init = 0;
  logic            e_valid;
  logic [5:0]      e_op, e_fn;
  logic [4:0]      e_sh, e_rs, e_rt, e_rd;
  logic [31:0]     e_rsd, e_rtd, e_imm;
  logic [PC_W-1:0] e_link;

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (wb_we && wb_addr == a) return wb_data;
    return m_rf[a];
  endfunction

  // {redirect, target} for the word now on instruc_reg
  function automatic logic [PC_W:0] m_redirect();
    int         op, tgt;
    bit         sel;
    logic [4:0] a, b;
    op  = int'(instruc_reg[31:26]);
    a   = instruc_reg[25:21];
    b   = instruc_reg[20:16];
    sel = 0;
    tgt = 0;
    if (reset || m_sq) return '0;
    case (op)
      2, 3: begin sel = 1; tgt = int'(instruc_reg[PC_W-1:0]); end
      0: if (instruc_reg[5:0] == 6'h08) begin
        sel = 1;
        tgt = int'(m_read(a) & 32'h3FF);
      end
      4, 5: begin
        sel = (op == 4) ? (m_read(a) == m_read(b))
                        : (m_read(a) != m_read(b));
        tgt = (int'(m_pc) + int'(instruc_reg[PC_W-1:0])) % (1 << PC_W);
      end
      default: ;
    endcase
    if (!sel) return '0;
    return {1'b1, tgt[PC_W-1:0]};
  endfunction

  always @(posedge clock) begin
    logic [PC_W:0] r;
    int op;
    r  = m_redirect();
    op = int'(instruc_reg[31:26]);
    {e_valid, e_op, e_fn, e_sh, e_rs, e_rt, e_rd} = '0;
    {e_rsd, e_rtd, e_imm, e_link} = '0;
    if (reset) begin
      for (int i = 0; i < 32; i++) m_rf[i] = '0;
      m_sq = 1'b1;
    end else begin
      if (!m_sq) begin
        e_valid = 1'b1;
        e_op  = instruc_reg[31:26];
        e_fn  = instruc_reg[5:0];
        e_sh  = instruc_reg[10:6];
        e_rs  = instruc_reg[25:21];
        e_rt  = instruc_reg[20:16];
        e_rsd = m_read(e_rs);
        e_rtd = m_read(e_rt);
        e_imm = 32'(signed'(instruc_reg[15:0]));
        case (op)
          3: e_rd = 5'd31;
          2, 4, 5: e_rd = 5'd0;
          0: e_rd = (e_fn == 6'h08) ? 5'd0 : instruc_reg[15:11];
          default: e_rd = instruc_reg[20:16];
        endcase
        if (op == 3) e_link = m_pc;
      end
      m_sq = r[PC_W];
      if (wb_we && wb_addr != 0) m_rf[wb_addr] = wb_data;
    end
    m_pc   = PC_plus_1;
    m_init = 1;
  end

  always @(negedge clock) begin
    logic [PC_W:0] r;
    #4;
    if (m_init) begin
      r = m_redirect();
      chk("m_ex_valid", ex_valid, e_valid);
      chk("m_ex_opcode", ex_opcode, e_op);
      chk("m_ex_funct", ex_funct, e_fn);
      chk("m_ex_shamt", ex_shamt, e_sh);
      chk("m_ex_rs", ex_rs, e_rs);
      chk("m_ex_rt", ex_rt, e_rt);
      chk("m_ex_rd", ex_rd, e_rd);
      chk("m_ex_rs_data", ex_rs_data, e_rsd);
      chk("m_ex_rt_data", ex_rt_data, e_rtd);
      chk("m_ex_imm", ex_imm, e_imm);
      chk("m_ex_link", ex_link, e_link);
      chk("m_PC_sel", PC_sel, r[PC_W]);
      chk("m_jump_address", jump_address, r[PC_W-1:0]);
    end
  end

  // Present one slot; returns just before the next rising edge.
  task automatic step(input logic rst, input logic [31:0] ins,
                      input int pc, input logic we = 1'b0,
                      input logic [4:0] wa = '0,
                      input logic [31:0] wd = '0);
    @(negedge clock);
    reset       = rst;
    instruc_reg = ins;
    PC_plus_1   = pc[PC_W-1:0];
    wb_we       = we;
    wb_addr     = wa;
    wb_data     = wd;
    #4;
  endtask

  initial begin
    step(1, 0, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    chk("reset ex_valid", ex_valid, 0);
    chk("reset PC_sel", PC_sel, 0);
    step(0, 32'h20010005, 1);
    step(0, 32'h20010005, 2);
    chk("first slot squashed", ex_valid, 0);
    step(0, 32'h00401820, 3, 1, 5'd2, 32'hDEADBEEF);
    chk("addi valid", ex_valid, 1);
    chk("addi rd", ex_rd, 1);
    chk("addi imm", ex_imm, 32'h5);
    step(0, 32'h00002020, 4, 1, 5'd0, 32'h7);
    chk("bypass rs_data", ex_rs_data, 32'hDEADBEEF);
    step(0, 32'h0, 5, 1, 5'd5, 32'h00000ABC);
    chk("r0 reads zero", ex_rs_data, 0);
    chk("add rd", ex_rd, 4);
    step(0, 32'h08000123, 6);
    chk("j sel", PC_sel, 1);
    chk("j target", jump_address, 32'h123);
    step(0, 32'h08000055, 7);
    chk("wrong path no redirect", PC_sel, 0);
    step(0, 32'h20060009, 1);
    chk("j shadow squashed", ex_valid, 0);
    step(0, 32'h1021FFFE, 3);
    chk("j target valid", ex_valid, 1);
    chk("beq taken", PC_sel, 1);
    chk("beq wrap", jump_address, 32'h3FF);
    step(0, 32'h0, 2);
    step(0, 32'h1421FFFE, 32'h011);
    chk("beq shadow squashed", ex_valid, 0);
    chk("bne not taken", PC_sel, 0);
    step(0, 32'h0C000040, 32'h012);
    chk("bne no squash", ex_valid, 1);
    chk("jal sel", PC_sel, 1);
    chk("jal target", jump_address, 32'h040);
    step(0, 32'h0, 32'h041);
    chk("jal rd", ex_rd, 31);
    chk("jal link", ex_link, 32'h011);
    step(0, 32'h00A00008, 32'h042);
    chk("jal shadow squashed", ex_valid, 0);
    chk("jr sel", PC_sel, 1);
    chk("jr target", jump_address, 32'h2BC);
    step(1, 32'h08000077, 32'h2BD);
    chk("reset PC_sel mid", PC_sel, 0);
    step(0, 32'h20070001, 32'h2BE);
    chk("reset ex_valid mid", ex_valid, 0);
    chk("reset ex_rd mid", ex_rd, 0);
    chk("reset ex_opcode mid", ex_opcode, 0);
    chk("reset ex_rs_data mid", ex_rs_data, 0);
    step(0, 32'h00401820, 32'h2BF);
    chk("post reset squashed", ex_valid, 0);
    step(1, 32'h08000200, 32'h2C0);
    chk("reset blocks j", PC_sel, 0);
    chk("rf cleared", ex_rs_data, 0);
    chk("post reset valid", ex_valid, 1);
    step(0, 32'h0, 32'h2C1);
    step(0, 32'h0, 32'h2C2);
    step(0, 32'h0, 32'h2C3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_decode.md
Name: instruction_decode

Overview:
- Decode stage directly downstream of instruction fetch. Consumes instruc_reg and PC_plus_1; returns PC_sel and jump_address to fetch.
- Holds the 32x32 register file. Resolves jumps and branches in decode with no delay slot, squashing the one wrong-path fetch.
- Drives a registered ID/EX pipeline latch toward execute.

Parameters:
- PC_W, 10, PC and instruction-address width (matches fetch)
- REG_N, 32, number of architectural registers (address width fixed at 5)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- instruc_reg  in  32  instruction word from fetch; BRAM output, one cycle behind PC
- PC_plus_1  in  PC_W  combinational PC_current+1 from fetch
- wb_we  in  1  register-file write enable from writeback
- wb_addr  in  5  writeback destination register
- wb_data  in  32  writeback data
- PC_sel  out  1  1 = fetch loads jump_address; combinational
- jump_address  out  PC_W  redirect target; combinational
- ex_valid  out  1  ID/EX slot holds a real instruction
- ex_opcode  out  6  instr[31:26]
- ex_funct  out  6  instr[5:0]
- ex_shamt  out  5  instr[10:6]
- ex_rs  out  5  instr[25:21]
- ex_rt  out  5  instr[20:16]
- ex_rd  out  5  destination: instr[15:11] for R-type, instr[20:16] for I-type, 31 for JAL
- ex_rs_data  out  32  register-file read of rs
- ex_rt_data  out  32  register-file read of rt
- ex_imm  out  32  sign-extended instr[15:0]
- ex_link  out  PC_W  return address for JAL (aligned PC+1)

Behaviour:
- Alignment: pc_d <= PC_plus_1 each cycle, giving PC_plus_1 of the instruction now on instruc_reg. All decode arithmetic uses pc_d.
- Slot validity: id_valid = ~squash. squash is a 1-bit register:
  - set by reset;
  - set in any cycle PC_sel = 1;
  - otherwise cleared.
  - The first instruction after reset release is therefore discarded.
- Register file:
  - REG_N x 32; r0 reads 0 and ignores writes.
  - Write occurs on the rising edge when wb_we = 1 and wb_addr != 0.
  - Reads are combinational with write-through bypass: when wb_we and wb_addr == rs (or rt) and addr != 0, wb_data is returned.
  - Reset clears all registers to 0.
  - A simultaneous write and reset: reset wins.
- Control transfer (qualified by id_valid; PC_sel = 0 when invalid):
  - J (opcode 000010) and JAL (000011): target = instr[PC_W-1:0].
  - JR (opcode 0, funct 001000): target = rs_data[PC_W-1:0].
  - BEQ (000100) is taken if rs_data == rt_data; BNE (000101) is taken if they differ. Target = pc_d + instr[PC_W-1:0], modulo 2^PC_W, so wrap-around is allowed.
  - Any other opcode: PC_sel = 0, jump_address = 0.
- Squash timing:
  - Redirect at cycle t: instruc_reg at t+1 is the word at PC+1 (wrong path) and is squashed.
  - The target instruction arrives at t+2.
  - Back-to-back redirects are impossible; a squashed slot never redirects.
- ID/EX latch: all ex_* outputs are registered.
  - On reset, every ex_* output is 0.
  - Otherwise ex_valid <= id_valid, and the fields load every cycle.
  - Invalid slots load zeros in all fields (a bubble equals a NOP, sll r0).
  - Jumps and branches still pass to execute with ex_valid = 1. Execute uses JAL's ex_rd = 31 and ex_link; other control-transfer instructions must not write back (their ex_rd is 0 for J, JR, BEQ, BNE).
- Reset mid-redirect: PC_sel is forced 0 during reset, and squash is set.
- No stall input. Decode accepts one instruction per cycle.

Test Plan:
- Reset 3 cycles, then feed ADDI r1,r0,5 (0x20010005). Required: the first post-reset slot has ex_valid = 0, and the next cycle shows ex_valid = 1, ex_rd = 1, ex_imm = 0x00000005.
- Write r2 = 0xDEADBEEF via wb, and in the same cycle decode ADD r3,r2,r0. Required: ex_rs_data = 0xDEADBEEF (bypass). Also write r0 = 7, then read r0. Required: 0.
- Feed J 0x123 (0x08000123). Required: PC_sel = 1 and jump_address = 0x123 in the same cycle; the next slot has ex_valid = 0; the slot after it is valid.
- BEQ r1,r1,-2 with pc_d = 0x001. Required: taken, jump_address = 0x3FF (wrap). BNE r1,r1 is required to be not taken, with no squash.
- JAL 0x040 at pc_d = 0x011. Required: ex_rd = 31, ex_link = 0x011. JR r5 with r5 = 0x0000_0ABC. Required: jump_address = 0x2BC.
- Assert reset for 1 cycle between a redirect and its target. Required: all ex_* = 0 and PC_sel = 0, followed by one squashed slot.
